// File: rtl/alu_result_fifo.sv
// Show-ahead FIFO buffering ALU results {select, y}, with sticky overflow flag.
// Optional per-entry zero flag (out_z) enabled by defining ALU_RESULT_FIFO_ZFLAG_EN.
module alu_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [2:0]               in_s,
  input  logic [3:0]               in_y,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [2:0]               out_s,
  output logic [3:0]               out_y,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  input  logic                     ovf_clr
`ifdef ALU_RESULT_FIFO_ZFLAG_EN
  ,
  output logic                     out_z
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if (DEPTH != 2 && DEPTH != 4 && DEPTH != 8) begin : g_bad_depth
      $error("alu_result_fifo: DEPTH must be 2, 4 or 8");
    end
  endgenerate

  typedef struct packed {
`ifdef ALU_RESULT_FIFO_ZFLAG_EN
    logic       z;
`endif
    logic [2:0] s;
    logic [3:0] y;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;

  logic            w_push;
  logic            w_pop;
  logic            w_full_try;
  entry_t          w_wr_entry;
  entry_t          w_head;
  logic [AW-1:0]   w_wptr_nxt;
  logic [AW-1:0]   w_rptr_nxt;

  // Handshake flags come only from the registered count, so reset clears them at once.
  assign in_ready   = (r_count < CW'(DEPTH));
  assign out_valid  = (r_count != '0);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;
  assign w_full_try = in_valid && !in_ready;

  assign w_wptr_nxt = (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
  assign w_rptr_nxt = (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;

  always_comb begin
    w_wr_entry   = '0;
    w_wr_entry.s = in_s;
    w_wr_entry.y = in_y;
`ifdef ALU_RESULT_FIFO_ZFLAG_EN
    w_wr_entry.z = (in_y == 4'h0);
`endif
  end

  // Storage needs no reset: stale entries are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= w_wptr_nxt;
      if (w_pop)  r_rptr <= w_rptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Set beats clear when both happen on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_ovf <= 1'b0;
    else if (w_full_try) r_ovf <= 1'b1;
    else if (ovf_clr)    r_ovf <= 1'b0;
  end

  always_comb begin
    w_head = '0;
    if (out_valid) w_head = r_mem[r_rptr];
  end

  assign out_s = w_head.s;
  assign out_y = w_head.y;
`ifdef ALU_RESULT_FIFO_ZFLAG_EN
  assign out_z = w_head.z;
`endif
  assign count = r_count;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo (DEPTH=4): stimulus queues expected heads,
// a negedge monitor checks every popped entry in order.
module tb_alu_result_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, ovf_clr;
  logic [2:0] in_s;
  logic [3:0] in_y;
  logic       in_ready, out_valid, ovf;
  logic [2:0] out_s;
  logic [3:0] out_y;
  logic [2:0] count;
`ifdef ALU_RESULT_FIFO_ZFLAG_EN
  logic       out_z;
`endif

  typedef struct {int s; int y; int z;} exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  alu_result_fifo #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_s(in_s), .in_y(in_y),
    .in_ready(in_ready), .out_valid(out_valid), .out_s(out_s), .out_y(out_y),
    .out_ready(out_ready), .count(count), .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef ALU_RESULT_FIFO_ZFLAG_EN
    , .out_z(out_z)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input int s, input int y);
    exp_t e;
    in_valid = 1'b1;
    in_s     = 3'(s);
    in_y     = 4'(y);
    e.s = s; e.y = y; e.z = (y == 0) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_count"},     int'(count),     0);
    chk({tag, "_out_y"},     int'(out_y),     0);
    chk({tag, "_out_s"},     int'(out_s),     0);
  endtask

  // Monitor: a pop happens at the next posedge when both handshake signals are high.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("pop_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pop_s", int'(out_s), e.s);
        chk("pop_y", int'(out_y), e.y);
`ifdef ALU_RESULT_FIFO_ZFLAG_EN
        chk("pop_z", int'(out_z), e.z);
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int tbl_y[4] = '{3, 10, 13, 1};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    in_s = '0; in_y = '0;
    #12;
    chk_empty("reset");
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_ovf", int'(ovf), 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // Fill to full with out_ready low.
    for (int i = 0; i < 4; i++) begin
      drive_push(i, tbl_y[i]);
      if (i == 0) chk("no_passthru_valid", int'(out_valid), 0);
      step();
    end
    in_valid = 1'b0;
    chk("full_count", int'(count), 4);
    chk("full_in_ready", int'(in_ready), 0);
    chk("full_out_valid", int'(out_valid), 1);
    chk("full_head_s", int'(out_s), 0);
    chk("full_head_y", int'(out_y), 3);

    // Overflow attempt leaves contents alone.
    in_valid = 1'b1; in_s = 3'd7; in_y = 4'hF;
    step();
    in_valid = 1'b0;
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_count", int'(count), 4);
    chk("ovf_head_y", int'(out_y), 3);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", int'(ovf), 0);
    // Set wins over clear on the same edge.
    in_valid = 1'b1; ovf_clr = 1'b1; in_y = 4'hF;
    step();
    in_valid = 1'b0; ovf_clr = 1'b0;
    chk("ovf_set_wins", int'(ovf), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr2", int'(ovf), 0);

    // Drain: monitor checks order 3,A,D,1.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk_empty("drained");
    chk("drained_q", q.size(), 0);
    // Pop while empty is a no-op.
    step();
    out_ready = 1'b0;
    chk("empty_pop_count", int'(count), 0);
    chk("empty_in_ready", int'(in_ready), 1);

    // Steady state at count=2 with simultaneous push/pop; pointers wrap.
    drive_push(6, 4'h9); step();
    drive_push(7, 4'h2); step();
    chk("pp_pre_count", int'(count), 2);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_push(i, i + 4);
      step();
      chk("pp_count", int'(count), 2);
    end
    in_valid = 1'b0;
    step(); step();
    out_ready = 1'b0;
    chk_empty("pp_drained");
    chk("pp_q", q.size(), 0);

    // Asynchronous reset mid-cycle with data and ovf set.
    for (int i = 0; i < 4; i++) begin
      drive_push(i + 1, 4'h5);
      step();
    end
    in_y = 4'hF;
    step();
    in_valid = 1'b0;
    chk("prerst_ovf", int'(ovf), 1);
    chk("prerst_count", int'(count), 4);
    #2 rst_n = 1'b0;
    #1;
    chk_empty("async_rst");
    chk("async_rst_ovf", int'(ovf), 0);
    chk("async_rst_in_ready", int'(in_ready), 1);
    q.delete();
    @(negedge clk); #2 rst_n = 1'b1;
    step();
    drive_push(5, 4'hC);
    step();
    in_valid = 1'b0;
    chk("post_rst_count", int'(count), 1);
    chk("post_rst_head_y", int'(out_y), 12);
    chk("post_rst_head_s", int'(out_s), 5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_empty("post_rst_drained");

`ifdef ALU_RESULT_FIFO_ZFLAG_EN
    drive_push(1, 0); step();
    drive_push(2, 5); step();
    in_valid = 1'b0;
    chk("z_first", int'(out_z), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("z_second", int'(out_z), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("z_empty", int'(out_z), 0);
`endif

    chk("final_q_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
